// File: rtl/frame_config_sequencer_if.sv
// Word-stream handshake between the bitstream loader (master) and the frame
// sequencer (slave).
interface frame_config_sequencer_if #(
    parameter int FrameBitsPerRow = 32
);
    logic [FrameBitsPerRow-1:0] WriteData;
    logic                       WriteValid;
    logic                       WriteReady;

    modport master (output WriteData, output WriteValid, input WriteReady);
    modport slave  (input WriteData, input WriteValid, output WriteReady);
endinterface

// File: rtl/frame_config_sequencer.sv
// Writes header-described bursts of frame words into column config latches,
// pulsing one FrameStrobe line per word with setup and hold cycles around it.
module frame_config_sequencer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 4,
    parameter int StrobeWidth     = 2
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    frame_config_sequencer_if.slave               wr,
    input  logic                                  ErrorClear,
    output logic [FrameBitsPerRow-1:0]            FrameData,
    output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
    output logic                                  Busy,
    output logic                                  Done,
    output logic                                  Error
);

    localparam int NumStrobes = MaxFramesPerCol * NumColumns;
    localparam int CntW       = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;

    typedef enum logic [2:0] {IDLE, DATA, SETUP, STROBE, HOLD} state_t;

    state_t                     state_q;
    logic [7:0]                 col_q, ptr_q, rem_q;
    logic [CntW-1:0]            cnt_q;
    logic [FrameBitsPerRow-1:0] data_q;
    logic [NumStrobes-1:0]      strobe_q, strobe_d;
    logic                       ready_q, busy_q, done_q, err_q;

    logic       accept;
    logic [7:0] hdr_sync, hdr_col, hdr_start, hdr_count;
    logic [8:0] hdr_end;
    logic       hdr_ok;

    function automatic logic [NumStrobes-1:0] strobe_onehot(input logic [7:0] col,
                                                            input logic [7:0] ptr);
        int idx;
        idx = int'(col) * MaxFramesPerCol + int'(ptr);
        for (int i = 0; i < NumStrobes; i++) strobe_onehot[i] = (i == idx);
    endfunction

    assign accept    = wr.WriteValid & ready_q;
    assign hdr_sync  = wr.WriteData[31:24];
    assign hdr_col   = wr.WriteData[23:16];
    assign hdr_start = wr.WriteData[15:8];
    assign hdr_count = wr.WriteData[7:0];
    // Nine-bit sum so a large start+count cannot wrap back into range.
    assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_count};
    assign hdr_ok    = (hdr_sync == 8'hFA) && (hdr_col < 8'(NumColumns)) &&
                       (hdr_count != 8'd0) && (hdr_end <= 9'(MaxFramesPerCol));
    assign strobe_d  = strobe_onehot(col_q, ptr_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            col_q    <= '0;
            ptr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A header error in the same cycle as ErrorClear keeps the flag set.
            if (state_q == IDLE && accept && !hdr_ok) err_q <= 1'b1;
            else if (ErrorClear)                      err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept && hdr_ok) begin
                        col_q   <= hdr_col;
                        ptr_q   <= hdr_start;
                        rem_q   <= hdr_count;
                        busy_q  <= 1'b1;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        data_q  <= wr.WriteData;
                        ready_q <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    strobe_q <= strobe_d;
                    cnt_q    <= '0;
                    state_q  <= STROBE;
                end
                STROBE: begin
                    if (cnt_q == CntW'(StrobeWidth - 1)) begin
                        strobe_q <= '0;
                        state_q  <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    rem_q   <= rem_q - 8'd1;
                    ptr_q   <= ptr_q + 8'd1;
                    ready_q <= 1'b1;
                    if (rem_q == 8'd1) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= DATA;
                    end
                end
                default: begin
                    strobe_q <= '0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign wr.WriteReady = ready_q;
    assign FrameData     = data_q;
    assign FrameStrobe   = strobe_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Error         = err_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed and randomized bursts against a header-rule reference model.
module tb_frame_config_sequencer;

    localparam int W   = 32;
    localparam int MF  = 20;
    localparam int NC  = 4;
    localparam int SW  = 2;
    localparam int NS  = MF * NC;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ErrorClear;
    logic [W-1:0]  FrameData;
    logic [NS-1:0] FrameStrobe;
    logic          Busy, Done, Error;

    frame_config_sequencer_if #(.FrameBitsPerRow(W)) wr ();

    frame_config_sequencer #(
        .FrameBitsPerRow(W), .MaxFramesPerCol(MF), .NumColumns(NC), .StrobeWidth(SW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .wr(wr), .ErrorClear(ErrorClear),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad   = 0;
    bit         err_m = 1'b0;
    logic [W-1:0] dq[$];

    task automatic chk(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NS-1:0] onehot(input int idx);
        logic [NS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Caller is at a negedge; returns just after the transferring posedge.
    task automatic send_word(input logic [W-1:0] w);
        int n;
        n = 0;
        wr.WriteData  = w;
        wr.WriteValid = 1'b1;
        while (!wr.WriteReady && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_timeout", NS'(n < 50), NS'(1));
        @(posedge CLK);
    endtask

    task automatic do_frame(input logic [W-1:0] d, input int idx, input bit last);
        send_word(d);
        @(negedge CLK);
        chk("setup_data", NS'(FrameData), NS'(d));
        chk("setup_strobe", FrameStrobe, '0);
        chk("setup_ready", NS'(wr.WriteReady), NS'(0));
        wr.WriteData = $urandom;
        for (int c = 0; c < SW; c++) begin
            @(negedge CLK);
            chk("strobe_line", FrameStrobe, onehot(idx));
            chk("strobe_data", NS'(FrameData), NS'(d));
        end
        @(negedge CLK);
        chk("hold_strobe", FrameStrobe, '0);
        chk("hold_data", NS'(FrameData), NS'(d));
        chk("hold_ready", NS'(wr.WriteReady), NS'(0));
        if (last) wr.WriteValid = 1'b0;
        @(negedge CLK);
        chk("exit_ready", NS'(wr.WriteReady), NS'(1));
        chk("exit_done", NS'(Done), NS'(last));
        chk("exit_busy", NS'(Busy), NS'(!last));
    endtask

    task automatic burst(input logic [W-1:0] hdr, input int gap, input bit rnd_gap);
        int  sync, col, st, cnt, g;
        bit  ok;
        logic [W-1:0] d;
        sync = int'(hdr >> 24);
        col  = int'((hdr >> 16) & 32'hFF);
        st   = int'((hdr >> 8) & 32'hFF);
        cnt  = int'(hdr & 32'hFF);
        ok   = (sync == 250) && (col < NC) && (cnt >= 1) && (st + cnt <= MF);
        send_word(hdr);
        @(negedge CLK);
        wr.WriteValid = 1'b0;
        if (!ok) begin
            err_m = 1'b1;
            chk("hdr_err_flag", NS'(Error), NS'(1));
            chk("hdr_err_busy", NS'(Busy), NS'(0));
            chk("hdr_err_strobe", FrameStrobe, '0);
            return;
        end
        chk("hdr_busy", NS'(Busy), NS'(1));
        chk("hdr_ready", NS'(wr.WriteReady), NS'(1));
        chk("hdr_error", NS'(Error), NS'(err_m));
        for (int k = 0; k < cnt; k++) begin
            g = rnd_gap ? int'($urandom_range(0, 3)) : ((k > 0) ? gap : 0);
            wr.WriteValid = 1'b0;
            for (int i = 0; i < g; i++) begin
                @(negedge CLK);
                chk("gap_strobe", FrameStrobe, '0);
                chk("gap_busy", NS'(Busy), NS'(1));
            end
            d = (dq.size() > 0) ? dq.pop_front() : W'($urandom);
            do_frame(d, col * MF + st + k, k == cnt - 1);
        end
        @(negedge CLK);
        chk("post_done", NS'(Done), NS'(0));
        chk("post_busy", NS'(Busy), NS'(0));
    endtask

    initial begin
        logic [W-1:0] hdr;
        logic [W-1:0] d;
        RESET         = 1'b1;
        ErrorClear    = 1'b0;
        wr.WriteValid = 1'b0;
        wr.WriteData  = '0;
        #12;
        chk("rst_data", NS'(FrameData), '0);
        chk("rst_strobe", FrameStrobe, '0);
        chk("rst_ready", NS'(wr.WriteReady), NS'(0));
        chk("rst_flags", NS'({Busy, Done, Error}), NS'(0));
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        dq.push_back(32'hDEADBEEF);
        burst(32'hFA010301, 0, 1'b0);

        dq.push_back(32'h0000000A);
        dq.push_back(32'h0000000B);
        burst(32'hFA031202, 0, 1'b0);

        burst(32'hFB010301, 0, 1'b0);
        burst(32'hFA040301, 0, 1'b0);
        burst(32'hFA010300, 0, 1'b0);
        burst(32'hFA011302, 0, 1'b0);
        ErrorClear = 1'b1;
        @(negedge CLK);
        ErrorClear = 1'b0;
        err_m = 1'b0;
        chk("err_clear", NS'(Error), NS'(0));

        burst(32'hFA000003, 10, 1'b0);

        // Clear racing a new header error: the set must win.
        ErrorClear = 1'b1;
        burst(32'hFA050001, 0, 1'b0);
        ErrorClear = 1'b0;
        chk("clear_vs_set", NS'(Error), NS'(1));
        burst(32'hFA020001, 0, 1'b0);

        send_word(32'hFA020501);
        @(negedge CLK);
        wr.WriteValid = 1'b0;
        d = 32'h12345678;
        send_word(d);
        @(negedge CLK);
        wr.WriteValid = 1'b0;
        @(negedge CLK);
        chk("pre_rst_strobe", FrameStrobe, onehot(2 * MF + 5));
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_strobe", FrameStrobe, '0);
        chk("async_rst_data", NS'(FrameData), '0);
        chk("async_rst_flags", NS'({Busy, Error, wr.WriteReady}), NS'(0));
        @(negedge CLK);
        RESET = 1'b0;
        err_m = 1'b0;
        @(negedge CLK);
        burst(32'hFA020501, 0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                hdr[31:24] = 8'hFA;
                hdr[23:16] = 8'($urandom_range(0, NC - 1));
                hdr[15:8]  = 8'($urandom_range(0, MF - 1));
                hdr[7:0]   = 8'($urandom_range(1, 4));
            end else begin
                hdr = $urandom;
                if ($urandom_range(0, 1) == 1) hdr[31:24] = 8'hFA;
            end
            burst(hdr, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
